// File: rtl/axinbroadcast_fifo.sv
// axinbroadcast_fifo
//   Broadcasts one AXIN source stream to NOUT destinations. The S_PORT mask is
//   sampled on the first beat of each packet. Every destination has its own
//   packet FIFO with a small per-port state machine, so a slow port can drop or
//   abort its copy of a packet (OPT_DROP=1) or stall the source (OPT_DROP=0)
//   without corrupting the other ports.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_cfg_active[NOUT]    per-port enable
//   S_*                   AXIN source: VALID/READY/DATA/BYTES/LAST/ABORT, PORT mask
//   M_*[NOUT]             AXIN destinations, DATA/BYTES packed port-major
//   o_drops[NOUT*DROPW]   per-port saturating count of dropped/overflow-aborted packets
//
// Per-port state machine
//   state   | meaning
//   IDLE    | between packets; waits for a first beat that targets this port
//   PASS    | forwarding the current packet into the FIFO
//   DROP    | discarding the rest of the current packet
module axinbroadcast_fifo #(
   parameter int NOUT         = 4,
   parameter int DW           = 64,
   parameter int WBITS        = $clog2(DW/8),
   parameter int LGFIFO       = 4,
   parameter bit OPT_DROP     = 1'b1,
   parameter bit OPT_LOWPOWER = 1'b0,
   parameter int DROPW        = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NOUT-1:0]        i_cfg_active,
   input  logic                   S_VALID,
   output logic                   S_READY,
   input  logic [DW-1:0]          S_DATA,
   input  logic [WBITS-1:0]       S_BYTES,
   input  logic                   S_LAST,
   input  logic                   S_ABORT,
   input  logic [NOUT-1:0]        S_PORT,
   output logic [NOUT-1:0]        M_VALID,
   input  logic [NOUT-1:0]        M_READY,
   output logic [NOUT*DW-1:0]     M_DATA,
   output logic [NOUT*WBITS-1:0]  M_BYTES,
   output logic [NOUT-1:0]        M_LAST,
   output logic [NOUT-1:0]        M_ABORT,
   output logic [NOUT*DROPW-1:0]  o_drops
);
   localparam int DEPTH = 1 << LGFIFO;
   localparam int CW    = LGFIFO + 1;
   // entry = {ABORT, LAST, BYTES, DATA}
   localparam int EW    = 2 + WBITS + DW;

   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} port_state_e;

   logic            s_midpkt_q, s_midpkt_d;
   logic            abort_eff;
   logic            beat_acc;
   logic            first_beat;
   logic [NOUT-1:0] port_blocks;

   // An abort only counts inside a packet; an abort cycle never carries a beat.
   assign abort_eff  = S_ABORT && (!S_VALID || S_READY) && s_midpkt_q;
   assign beat_acc   = S_VALID && S_READY && !abort_eff;
   assign first_beat = beat_acc && !s_midpkt_q;

   always_comb begin
      s_midpkt_d = s_midpkt_q;
      if (abort_eff)
         s_midpkt_d = 1'b0;
      else if (beat_acc)
         s_midpkt_d = !S_LAST;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         s_midpkt_q <= 1'b0;
      else
         s_midpkt_q <= s_midpkt_d;
   end

   assign S_READY = !i_reset && (OPT_DROP || (port_blocks == '0));

   for (genvar k = 0; k < NOUT; k++) begin : g_port
      port_state_e       state_q, state_d;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
      logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
      logic [DROPW-1:0]  drops_q, drops_d;
      logic [EW-1:0]     mem_q [DEPTH];
      logic [EW-1:0]     push_ent;
      logic [EW-1:0]     head;
      logic              push, pop, drop_inc;
      logic              room, targeted, not_empty, head_abort, show;

      // Two free slots are needed to start or continue a packet so that an
      // abort marker can always be appended later.
      assign room       = (cnt_q <= CW'(DEPTH - 2));
      assign not_empty  = (cnt_q != '0);
      assign head       = mem_q[rd_ptr_q];
      assign head_abort = head[EW-1];
      // Abort markers leave the head after one cycle regardless of M_READY.
      assign pop        = not_empty && (head_abort || M_READY[k]);

      assign targeted = i_cfg_active[k] &&
                        ((state_q == ST_IDLE) ? S_PORT[k] : (state_q == ST_PASS));
      assign port_blocks[k] = targeted && !room;

      always_comb begin
         state_d  = state_q;
         push     = 1'b0;
         push_ent = {1'b1, {(EW-1){1'b0}}};
         drop_inc = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (first_beat && S_PORT[k] && i_cfg_active[k]) begin
                  if (room) begin
                     push     = 1'b1;
                     push_ent = {1'b0, S_LAST, S_BYTES, S_DATA};
                     if (!S_LAST)
                        state_d = ST_PASS;
                  end else if (OPT_DROP) begin
                     drop_inc = 1'b1;
                     if (!S_LAST)
                        state_d = ST_DROP;
                  end
               end
            end
            ST_PASS: begin
               if (abort_eff) begin
                  push    = 1'b1;
                  state_d = ST_IDLE;
               end else if (!i_cfg_active[k]) begin
                  push    = 1'b1;
                  state_d = (beat_acc && S_LAST) ? ST_IDLE : ST_DROP;
               end else if (beat_acc) begin
                  if (room) begin
                     push     = 1'b1;
                     push_ent = {1'b0, S_LAST, S_BYTES, S_DATA};
                     state_d  = S_LAST ? ST_IDLE : ST_PASS;
                  end else begin
                     push     = 1'b1;
                     drop_inc = 1'b1;
                     state_d  = S_LAST ? ST_IDLE : ST_DROP;
                  end
               end
            end
            ST_DROP: begin
               if (abort_eff || (beat_acc && S_LAST))
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_comb begin
         cnt_d    = cnt_q + CW'(push) - CW'(pop);
         wr_ptr_d = wr_ptr_q + LGFIFO'(push);
         rd_ptr_d = rd_ptr_q + LGFIFO'(pop);
         drops_d  = drops_q;
         if (drop_inc && (drops_q != '1))
            drops_d = drops_q + DROPW'(1);
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
         if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drops_q  <= '0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drops_q  <= drops_d;
         end
      end

      always_ff @(posedge i_clk) begin
         if (push)
            mem_q[wr_ptr_q] <= push_ent;
      end

      // Payload is forced to zero whenever nothing meaningful is at the head,
      // which also keeps every output at zero while reset holds the FIFO empty.
      assign show = OPT_LOWPOWER ? M_VALID[k] : not_empty;

      assign M_VALID[k]                 = not_empty && !head_abort;
      assign M_ABORT[k]                 = not_empty && head_abort;
      assign M_DATA[k*DW +: DW]         = show ? head[DW-1:0] : '0;
      assign M_BYTES[k*WBITS +: WBITS]  = show ? head[DW +: WBITS] : '0;
      assign M_LAST[k]                  = show && head[EW-2];
      assign o_drops[k*DROPW +: DROPW]  = drops_q;
   end

endmodule

// File: tb/tb_axinbroadcast_fifo.sv
// Randomized bench for axinbroadcast_fifo. Two instances share one source and
// sink stimulus: inst 0 uses OPT_DROP=1, inst 1 uses OPT_DROP=0. The source
// obeys AXIN handshaking against inst 1; inst 0 is always ready and therefore
// sees repeated beats while inst 1 stalls. Each instance has its own queue
// based reference model.
module tb_axinbroadcast_fifo;
   localparam int NOUT  = 4;
   localparam int DW    = 64;
   localparam int WB    = 3;
   localparam int DEPTH = 16;
   localparam int DROPW = 16;
   localparam int MD_IDLE = 0;
   localparam int MD_PASS = 1;
   localparam int MD_DROP = 2;

   typedef struct packed {
      logic          ab;
      logic          last;
      logic [WB-1:0] bytes;
      logic [DW-1:0] data;
   } ent_t;

   logic                  clk;
   logic                  rst;
   logic [NOUT-1:0]       cfg_active;
   logic                  s_valid;
   logic [DW-1:0]         s_data;
   logic [WB-1:0]         s_bytes;
   logic                  s_last;
   logic                  s_abort;
   logic [NOUT-1:0]       s_port;
   logic [NOUT-1:0]       m_ready;

   logic                  s_ready [2];
   logic [NOUT-1:0]       m_valid [2];
   logic [NOUT*DW-1:0]    m_data  [2];
   logic [NOUT*WB-1:0]    m_bytes [2];
   logic [NOUT-1:0]       m_last  [2];
   logic [NOUT-1:0]       m_abort [2];
   logic [NOUT*DROPW-1:0] drops   [2];

   int total = 0;
   int bad   = 0;

   ent_t mq [2*NOUT][$];
   int   mode [2*NOUT];
   int   mdrops [2*NOUT];
   bit   mid [2];
   bit   acc_b;

   int          pkt_len, pkt_idx, abort_at;
   logic [3:0]  pkt_port;

   axinbroadcast_fifo #(.NOUT(NOUT), .DW(DW), .LGFIFO(4), .OPT_DROP(1'b1),
                        .OPT_LOWPOWER(1'b0), .DROPW(DROPW)) dut_drop (
      .i_clk(clk), .i_reset(rst), .i_cfg_active(cfg_active),
      .S_VALID(s_valid), .S_READY(s_ready[0]), .S_DATA(s_data), .S_BYTES(s_bytes),
      .S_LAST(s_last), .S_ABORT(s_abort), .S_PORT(s_port),
      .M_VALID(m_valid[0]), .M_READY(m_ready), .M_DATA(m_data[0]), .M_BYTES(m_bytes[0]),
      .M_LAST(m_last[0]), .M_ABORT(m_abort[0]), .o_drops(drops[0]));

   axinbroadcast_fifo #(.NOUT(NOUT), .DW(DW), .LGFIFO(4), .OPT_DROP(1'b0),
                        .OPT_LOWPOWER(1'b0), .DROPW(DROPW)) dut_bp (
      .i_clk(clk), .i_reset(rst), .i_cfg_active(cfg_active),
      .S_VALID(s_valid), .S_READY(s_ready[1]), .S_DATA(s_data), .S_BYTES(s_bytes),
      .S_LAST(s_last), .S_ABORT(s_abort), .S_PORT(s_port),
      .M_VALID(m_valid[1]), .M_READY(m_ready), .M_DATA(m_data[1]), .M_BYTES(m_bytes[1]),
      .M_LAST(m_last[1]), .M_ABORT(m_abort[1]), .o_drops(drops[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2*NOUT; i++) begin
         mq[i].delete();
         mode[i]   = MD_IDLE;
         mdrops[i] = 0;
      end
      mid[0] = 1'b0;
      mid[1] = 1'b0;
      acc_b  = 1'b0;
   endtask

   // Source readiness as the model sees it: OPT_DROP=1 is always ready;
   // otherwise every port that would take the beat must have two free slots.
   function automatic bit model_ready(input int inst);
      if (inst == 0)
         return 1'b1;
      for (int k = 0; k < NOUT; k++) begin
         bit tgt;
         int idx;
         idx = inst*NOUT + k;
         tgt = cfg_active[k] && ((mode[idx] == MD_IDLE) ? s_port[k] : (mode[idx] == MD_PASS));
         if (tgt && (DEPTH - mq[idx].size()) < 2)
            return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic compare(input int inst);
      check_eq($sformatf("i%0d s_ready", inst), 64'(s_ready[inst]), 64'(model_ready(inst)));
      for (int k = 0; k < NOUT; k++) begin
         int   idx;
         bit   ev, ea;
         ent_t h;
         idx = inst*NOUT + k;
         h   = '0;
         if (mq[idx].size() > 0)
            h = mq[idx][0];
         ev = (mq[idx].size() > 0) && !h.ab;
         ea = (mq[idx].size() > 0) && h.ab;
         check_eq($sformatf("i%0d p%0d m_valid", inst, k), 64'(m_valid[inst][k]), 64'(ev));
         check_eq($sformatf("i%0d p%0d m_abort", inst, k), 64'(m_abort[inst][k]), 64'(ea));
         check_eq($sformatf("i%0d p%0d drops", inst, k),
                  64'(drops[inst][k*DROPW +: DROPW]), 64'(mdrops[idx]));
         if (ev) begin
            check_eq($sformatf("i%0d p%0d m_data", inst, k), m_data[inst][k*DW +: DW], h.data);
            check_eq($sformatf("i%0d p%0d m_bytes", inst, k),
                     64'(m_bytes[inst][k*WB +: WB]), 64'(h.bytes));
            check_eq($sformatf("i%0d p%0d m_last", inst, k), 64'(m_last[inst][k]), 64'(h.last));
         end
      end
   endtask

   task automatic model_step(input int inst);
      bit rdy, abort_e, beat, first;
      rdy     = model_ready(inst);
      abort_e = s_abort && (!s_valid || rdy) && mid[inst];
      beat    = s_valid && rdy && !abort_e;
      first   = beat && !mid[inst];
      for (int k = 0; k < NOUT; k++) begin
         int   idx, sz;
         bit   room, do_pop, do_push, inc;
         ent_t e, mk;
         idx     = inst*NOUT + k;
         sz      = mq[idx].size();
         room    = (DEPTH - sz) >= 2;
         do_pop  = (sz > 0) && (mq[idx][0].ab || m_ready[k]);
         do_push = 1'b0;
         inc     = 1'b0;
         mk      = '0;
         mk.ab   = 1'b1;
         e       = {1'b0, s_last, s_bytes, s_data};
         case (mode[idx])
            MD_IDLE: begin
               if (first && s_port[k] && cfg_active[k]) begin
                  if (room) begin
                     do_push = 1'b1;
                     if (!s_last) mode[idx] = MD_PASS;
                  end else if (inst == 0) begin
                     inc = 1'b1;
                     if (!s_last) mode[idx] = MD_DROP;
                  end
               end
            end
            MD_PASS: begin
               if (abort_e) begin
                  do_push = 1'b1; e = mk; mode[idx] = MD_IDLE;
               end else if (!cfg_active[k]) begin
                  do_push = 1'b1; e = mk;
                  mode[idx] = (beat && s_last) ? MD_IDLE : MD_DROP;
               end else if (beat) begin
                  do_push = 1'b1;
                  if (!room) begin
                     e = mk; inc = 1'b1;
                     mode[idx] = s_last ? MD_IDLE : MD_DROP;
                  end else begin
                     mode[idx] = s_last ? MD_IDLE : MD_PASS;
                  end
               end
            end
            default: begin
               if (abort_e || (beat && s_last))
                  mode[idx] = MD_IDLE;
            end
         endcase
         if (do_pop)
            void'(mq[idx].pop_front());
         if (do_push)
            mq[idx].push_back(e);
         if (inc && mdrops[idx] < 65535)
            mdrops[idx]++;
      end
      if (abort_e)
         mid[inst] = 1'b0;
      else if (beat)
         mid[inst] = !s_last;
      if (inst == 1)
         acc_b = beat;
   endtask

   task automatic new_packet(input int phase);
      pkt_idx  = 0;
      abort_at = -1;
      case (phase)
         0:       begin pkt_len = $urandom_range(1, 6);   pkt_port = 4'hF; end
         1:       begin pkt_len = $urandom_range(16, 24); pkt_port = 4'hF; end
         default: begin
            pkt_len  = $urandom_range(1, 20);
            pkt_port = 4'($urandom);
            if (pkt_len > 2 && $urandom_range(0, 5) == 0)
               abort_at = $urandom_range(1, pkt_len - 1);
         end
      endcase
   endtask

   task automatic drive(input int phase);
      bit hold;
      hold = s_valid && !acc_b;
      if (s_abort) begin
         s_abort = 1'b0;
         new_packet(phase);
      end else if (s_valid && acc_b) begin
         if (s_last) new_packet(phase);
         else        pkt_idx++;
      end
      if (!hold) begin
         if (pkt_idx > 0 && pkt_idx == abort_at) begin
            s_valid  = 1'b0;
            s_abort  = 1'b1;
            abort_at = -1;
         end else begin
            s_valid = ($urandom_range(0, 9) < 8);
            s_data  = {$urandom, $urandom};
            s_bytes = 3'($urandom);
            s_last  = (pkt_idx == pkt_len - 1);
         end
      end
      s_port = pkt_port;
      case (phase)
         0:       m_ready = 4'hF;
         1:       m_ready = 4'b1011;
         default: begin
            for (int k = 0; k < NOUT; k++)
               m_ready[k] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0)
               cfg_active[$urandom_range(0, NOUT-1)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0)
               cfg_active = 4'hF;
         end
      endcase
   endtask

   task automatic run_phase(input int phase, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         drive(phase);
         @(negedge clk);
         compare(0);
         compare(1);
         model_step(0);
         model_step(1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s i%0d s_ready", tag, i), 64'(s_ready[i]), 64'd0);
         check_eq($sformatf("%s i%0d m_valid", tag, i), 64'(m_valid[i]), 64'd0);
         check_eq($sformatf("%s i%0d m_abort", tag, i), 64'(m_abort[i]), 64'd0);
         check_eq($sformatf("%s i%0d m_last", tag, i), 64'(m_last[i]), 64'd0);
         check_eq($sformatf("%s i%0d m_bytes", tag, i), 64'(m_bytes[i]), 64'd0);
         check_eq($sformatf("%s i%0d m_data", tag, i), 64'(|m_data[i]), 64'd0);
         check_eq($sformatf("%s i%0d drops", tag, i), drops[i], 64'd0);
      end
   endtask

   task automatic restart_source();
      s_valid = 1'b0;
      s_abort = 1'b0;
      s_last  = 1'b0;
      new_packet(0);
   endtask

   initial begin
      rst        = 1'b0;
      cfg_active = 4'hF;
      s_valid    = 1'b0;
      s_data     = '0;
      s_bytes    = '0;
      s_last     = 1'b0;
      s_abort    = 1'b0;
      s_port     = 4'hF;
      m_ready    = 4'h0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      restart_source();
      @(posedge clk);
      #1;

      run_phase(0, 60);
      run_phase(1, 80);
      run_phase(2, 1500);

      // asynchronous reset between clock edges, usually mid-packet
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cfg_active = 4'hF;
      restart_source();
      @(posedge clk);
      #1;

      run_phase(0, 20);
      run_phase(3, 800);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axinbroadcast_fifo.md
Name: axinbroadcast_fifo

Overview:
- Next-generation packet broadcaster. One AXI-network (AXIN) source fans out to NOUT destinations, selected per packet by a port mask.
- Each destination has its own packet FIFO, so a slow port no longer stalls the others.
- OPT_DROP chooses per-port drop-with-abort over global backpressure.
- Sits between the router's port-select stage and the per-port TX paths of the switch.

Parameters:
- NOUT, 4, number of destination ports.
- DW, 64, data bits per beat.
- WBITS, $clog2(DW/8), width of the BYTES field.
- LGFIFO, 4, log2 of per-port FIFO depth (entries, including the output register); minimum 2.
- OPT_DROP, 1, 1: never stall the source; full ports drop or abort. 0: stall the source while any targeted active port lacks room.
- OPT_LOWPOWER, 0, zero M_DATA/M_BYTES/M_LAST whenever M_VALID is low.
- DROPW, 16, width of each per-port drop counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_cfg_active  in  NOUT  per-port enable.
- S_VALID  in  1  source beat valid.
- S_READY  out  1  source ready.
- S_DATA  in  DW  beat data.
- S_BYTES  in  WBITS  valid bytes on the last beat (0 = all).
- S_LAST  in  1  last beat of packet.
- S_ABORT  in  1  abort current packet.
- S_PORT  in  NOUT  destination mask; sampled on the first beat, held for the whole packet.
- M_VALID  out  NOUT  per-port beat valid.
- M_READY  in  NOUT  per-port ready.
- M_DATA  out  NOUT*DW  per-port data.
- M_BYTES  out  NOUT*WBITS  per-port bytes.
- M_LAST  out  NOUT  per-port last.
- M_ABORT  out  NOUT  per-port abort.
- o_drops  out  NOUT*DROPW  per-port saturating count of dropped or aborted-for-overflow packets.

Behaviour:
- Reset: asynchronous; clears all FIFOs, states, s_midpkt and counters. All outputs are 0 during and after reset. S_READY is 0 while reset is asserted.
- Acceptance: a beat is accepted when S_VALID && S_READY. s_midpkt tracks the source packet exactly as AXIN defines: set by an accepted non-last beat, cleared by an accepted last beat or by an abort.
- An abort takes effect when S_ABORT && (!S_VALID || S_READY) and s_midpkt is set.
- FIFO entry format: {ABORT, LAST, BYTES, DATA}. free[k] = 2^LGFIFO − occupancy[k].
- Per-port state machine, states IDLE, PASS and DROP:
  - IDLE → PASS: first beat, S_PORT[k] set, i_cfg_active[k] set, free ≥ 2. The beat is pushed; a single-beat packet stays in IDLE.
  - IDLE → DROP: first beat with S_PORT[k] && i_cfg_active[k] && free < 2 (OPT_DROP=1 only). o_drops[k] increments. Multi-beat packets only; a single-beat packet is dropped and the port stays in IDLE.
  - PASS: each accepted beat is pushed while free ≥ 2. On LAST the port returns to IDLE.
  - PASS overflow: with free < 2 (OPT_DROP=1), push an abort marker, increment o_drops[k], go to DROP.
  - PASS source abort: push an abort marker, go to IDLE.
  - PASS with i_cfg_active[k] falling: push an abort marker, go to DROP. The marker always fits because one slot is reserved.
  - DROP: discard beats. Return to IDLE on an accepted LAST or on an abort.
  - A port not in S_PORT or inactive at the first beat ignores the whole packet.
- S_READY:
  - OPT_DROP=1: constant 1 out of reset.
  - OPT_DROP=0: 1 only if every port k with i_cfg_active[k] && (IDLE ? S_PORT[k] : PASS) has free ≥ 2.
- Output side:
  - Output is registered: a beat pushed into an empty FIFO at cycle N appears on M_VALID[k] at N+1.
  - Data beats follow AXIN rules: M_VALID held with stable payload until M_READY.
  - Abort marker at the head: M_ABORT[k]=1 and M_VALID[k]=0 for exactly one cycle, then the marker pops without waiting for M_READY.
  - When a marker follows data, all preceding beats drain first.
- Simultaneous push and pop keeps occupancy unchanged. A full FIFO never accepts a push; the reserve rule guarantees this.
- o_drops[k] saturates at 2^DROPW−1.

Test Plan:
- Broadcast, NOUT=4, LGFIFO=4: 3-beat packet, S_PORT=4'b1111, all M_READY=1 → each port shows beats at cycles 1,2,3; M_LAST on the third; o_drops all 0.
- Stalled port, OPT_DROP=1: M_READY[2]=0 with a 20-beat packet to all ports.
  - Ports 0,1,3 receive all 20 beats.
  - Port 2 holds 15 data beats plus an abort marker; o_drops[2]=1.
  - Port 2 then drains 15 beats followed by a one-cycle M_ABORT[2].
- Backpressure, OPT_DROP=0: same stimulus → S_READY falls after 15 beats are buffered in port 2. No data is lost; raising M_READY[2] completes all 20 beats on every port.
- Source abort: S_ABORT asserted after beat 2 of a 5-beat packet to port 1 → port 1 emits 2 beats, then M_ABORT[1] for one cycle; the next packet passes intact.
- i_cfg_active[3] drops mid-packet → M_ABORT[3] after the buffered beats. Port 3 stays silent until the next packet's first beat with the port active again.
- Asynchronous reset mid-packet: all outputs go to 0 immediately; the FIFOs are empty after release; a subsequent packet is delivered normally.
